// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter. A single-cycle ALU writeback (A) has
// priority over a long-latency writeback (B), with a starvation counter that
// freezes A so B always makes progress. A scoreboard tracks registers that
// still await a B write and flags decode-stage hazards.
module wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_a_we,
  input  logic [4:0]  i_a_addr,
  input  logic [31:0] i_a_data,
  input  logic        i_b_valid,
  input  logic [4:0]  i_b_addr,
  input  logic [31:0] i_b_data,
  output logic        o_b_ready,
  input  logic        i_issue,
  input  logic [4:0]  i_issue_addr,
  input  logic [4:0]  i_Rs,
  input  logic [4:0]  i_Rt,
  output logic        o_hazard,
  output logic        o_stall_a,
  output logic        o_regWrite,
  output logic [4:0]  o_wrAddr,
  output logic [31:0] o_wrDataToReg,
  output logic [31:0] o_pending
);

  localparam logic [3:0] LimitCnt = 4'(STARVE_LIMIT);

  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [4:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        src_b_q, src_b_d;
  logic [31:0] pending_q, pending_d;
  logic        a_valid;
  logic        b_grant;

  // Grant decision: A wins unless frozen; B stays low while in reset.
  always_comb begin
    o_stall_a = (cnt_q == LimitCnt);
    a_valid   = i_a_we && (i_a_addr != 5'd0) && !o_stall_a;
    b_grant   = i_b_valid && !a_valid && i_rst_n;
    o_b_ready = b_grant;
  end

  // Starvation counter: counts refused B cycles, saturating at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (!i_b_valid || b_grant) begin
      cnt_d = 4'd0;
    end else if (cnt_q != LimitCnt) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Output stage next state; a B write to r0 is accepted but dropped.
  always_comb begin
    wr_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    src_b_d = src_b_q;
    if (a_valid) begin
      wr_d    = 1'b1;
      addr_d  = i_a_addr;
      data_d  = i_a_data;
      src_b_d = 1'b0;
    end else if (b_grant) begin
      wr_d    = (i_b_addr != 5'd0);
      addr_d  = i_b_addr;
      data_d  = i_b_data;
      src_b_d = 1'b1;
    end
  end

  // Scoreboard next state; set is applied after clear so set wins.
  always_comb begin
    pending_d = pending_q;
    if (wr_q && src_b_q) begin
      pending_d[addr_q] = 1'b0;
    end
    if (i_issue && (i_issue_addr != 5'd0)) begin
      pending_d[i_issue_addr] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // State registers with asynchronous clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q     <= 4'd0;
      wr_q      <= 1'b0;
      addr_q    <= 5'd0;
      data_q    <= 32'd0;
      src_b_q   <= 1'b0;
      pending_q <= 32'd0;
    end else begin
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      src_b_q   <= src_b_d;
      pending_q <= pending_d;
    end
  end

  // Registered write port, scoreboard and hazard outputs.
  always_comb begin
    o_regWrite    = wr_q;
    o_wrAddr      = addr_q;
    o_wrDataToReg = data_q;
    o_pending     = pending_q;
    o_hazard      = pending_q[i_Rs] | pending_q[i_Rt];
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with hand-computed expectations.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_we, b_valid, issue;
  logic [4:0]  a_addr, b_addr, issue_addr, rs, rt;
  logic [31:0] a_data, b_data;
  logic        b_ready, hazard, stall_a, reg_write;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data, pending;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_a_we       (a_we),
    .i_a_addr     (a_addr),
    .i_a_data     (a_data),
    .i_b_valid    (b_valid),
    .i_b_addr     (b_addr),
    .i_b_data     (b_data),
    .o_b_ready    (b_ready),
    .i_issue      (issue),
    .i_issue_addr (issue_addr),
    .i_Rs         (rs),
    .i_Rt         (rt),
    .o_hazard     (hazard),
    .o_stall_a    (stall_a),
    .o_regWrite   (reg_write),
    .o_wrAddr     (wr_addr),
    .o_wrDataToReg(wr_data),
    .o_pending    (pending)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    a_we = 0; a_addr = 0; a_data = 0;
    b_valid = 0; b_addr = 0; b_data = 0;
    issue = 0; issue_addr = 0; rs = 0; rt = 0;
  endtask

  // Advance to just after the next rising edge (start of the next cycle).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle();
    #12;
    @(negedge clk);
    rst_n = 1;
    tick();
  endtask

  initial begin
    idle();
    rst_n = 0;
    b_valid = 1;
    #12;
    check("rst_regwrite", 32'(reg_write), 0);
    check("rst_wraddr", 32'(wr_addr), 0);
    check("rst_wrdata", wr_data, 0);
    check("rst_pending", pending, 0);
    check("rst_stall", 32'(stall_a), 0);
    check("rst_hazard", 32'(hazard), 0);
    check("rst_bready", 32'(b_ready), 0);
    @(negedge clk);
    rst_n = 1;
    b_valid = 0;
    tick();

    // A only
    a_we = 1; a_addr = 5; a_data = 32'hDEADBEEF;
    tick();
    idle(); #1;
    check("a_wr", 32'(reg_write), 1);
    check("a_addr", 32'(wr_addr), 5);
    check("a_data", wr_data, 32'hDEADBEEF);
    tick();
    check("a_wr_end", 32'(reg_write), 0);

    // Conflict: A every cycle, B to r9 refused four cycles then forced through
    for (int c = 0; c < 4; c++) begin
      a_we = 1; a_addr = 1; a_data = 32'(c);
      b_valid = 1; b_addr = 9; b_data = 32'h11;
      #1;
      check($sformatf("cf_bready_c%0d", c), 32'(b_ready), 0);
      check($sformatf("cf_stall_c%0d", c), 32'(stall_a), 0);
      tick();
    end
    #1;
    check("cf_stall_c4", 32'(stall_a), 1);
    check("cf_bready_c4", 32'(b_ready), 1);
    check("cf_a_write_c4", 32'(wr_addr), 1);
    tick();
    b_valid = 0; #1;
    check("cf_b_wr", 32'(reg_write), 1);
    check("cf_b_addr", 32'(wr_addr), 9);
    check("cf_b_data", wr_data, 32'h11);
    check("cf_stall_c5", 32'(stall_a), 0);
    tick();
    // Counter must be back at 0: a fresh B refusal must not stall yet.
    b_valid = 1; #1;
    check("cf_cnt_cleared", 32'(stall_a), 0);
    check("cf_a_wins", 32'(b_ready), 0);
    idle();
    tick();

    // Scoreboard set / hazard / clear by B write
    issue = 1; issue_addr = 7;
    tick();
    idle(); rt = 7; #1;
    check("sb_pending7", pending, 32'h80);
    check("sb_hazard", 32'(hazard), 1);
    tick();
    tick();
    b_valid = 1; b_addr = 7; b_data = 32'h77; #1;
    check("sb_bready", 32'(b_ready), 1);
    tick();
    b_valid = 0; #1;
    check("sb_b_wr", 32'(reg_write), 1);
    check("sb_b_addr", 32'(wr_addr), 7);
    tick();
    check("sb_cleared", pending, 0);
    check("sb_hazard_off", 32'(hazard), 0);
    idle();

    // An A write never clears a pending bit
    issue = 1; issue_addr = 4;
    tick();
    issue = 0; a_we = 1; a_addr = 4; a_data = 32'h44;
    tick();
    idle();
    tick();
    check("a_no_clear", pending, 32'h10);

    // Register zero
    a_we = 1; a_addr = 0; a_data = 32'h99;
    tick();
    idle(); #1;
    check("r0_a_nowrite", 32'(reg_write), 0);
    issue = 1; issue_addr = 0;
    tick();
    idle(); #1;
    check("r0_issue", pending, 32'h10);
    b_valid = 1; b_addr = 0; b_data = 32'h5; #1;
    check("r0_b_ready", 32'(b_ready), 1);
    tick();
    idle(); #1;
    check("r0_b_nowrite", 32'(reg_write), 0);

    // Same-edge set and clear of r3: set wins
    issue = 1; issue_addr = 3;
    tick();
    issue = 0; b_valid = 1; b_addr = 3; b_data = 32'h33;
    tick();
    b_valid = 0; issue = 1; issue_addr = 3; #1;
    check("se_b_wr3", 32'(reg_write), 1);
    tick();
    idle(); #1;
    check("se_pending3", 32'(pending[3]), 1);

    // Reset asserted during a stall cycle
    do_reset();
    issue = 1; issue_addr = 7;
    tick();
    issue = 0;
    for (int c = 0; c < 4; c++) begin
      a_we = 1; a_addr = 2; a_data = 32'h2;
      b_valid = 1; b_addr = 6; b_data = 32'h66;
      tick();
    end
    #1;
    check("rs_stall_pre", 32'(stall_a), 1);
    check("rs_pending_pre", pending, 32'h80);
    rt = 7;
    rst_n = 0; #1;
    check("rs_regwrite", 32'(reg_write), 0);
    check("rs_wraddr", 32'(wr_addr), 0);
    check("rs_wrdata", wr_data, 0);
    check("rs_pending", pending, 0);
    check("rs_stall", 32'(stall_a), 0);
    check("rs_hazard", 32'(hazard), 0);
    check("rs_bready", 32'(b_ready), 0);
    @(negedge clk);
    idle();
    rst_n = 1;
    tick();
    a_we = 1; a_addr = 2; a_data = 32'h22;
    tick();
    idle(); #1;
    check("rs_a_wr", 32'(reg_write), 1);
    check("rs_a_addr", 32'(wr_addr), 2);
    check("rs_a_data", wr_data, 32'h22);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, consecutive cycles a valid B request may be refused before port A is frozen; legal range 1..15.
REQ-002 i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 i_rst_n  input  1  reset; asynchronous, active-low.
REQ-004 i_a_we / i_a_addr / i_a_data  input  1/5/32  single-cycle ALU writeback request; not back-pressurable except via o_stall_a.
REQ-005 i_b_valid / i_b_addr / i_b_data  input  1/5/32  long-latency unit (load/mul) writeback request; held stable until accepted.
REQ-006 o_b_ready  output  1  B request accepted this cycle.
REQ-007 i_issue / i_issue_addr  input  1/5  long-latency instruction issued with this destination register.
REQ-008 i_Rs / i_Rt  input  5/5  source registers of the instruction in decode.
REQ-009 o_hazard  output  1  a source register has an outstanding B write.
REQ-010 o_stall_a  output  1  A pipeline shall freeze this cycle.
REQ-011 o_regWrite / o_wrAddr / o_wrDataToReg  output  1/5/32  registered write port into the register file.
REQ-012 o_pending  output  32  scoreboard, one bit per register.

Function
REQ-013 Write port is registered: a request granted in cycle N drives o_regWrite=1, o_wrAddr, o_wrDataToReg in cycle N+1 only; o_regWrite=0 in any cycle with no grant in the previous cycle.
REQ-014 A request valid iff i_a_we=1, i_a_addr!=0, o_stall_a=0; a valid A request is always granted.
REQ-015 B granted iff i_b_valid=1 and no valid A request; o_b_ready is combinational and equals the B grant.
REQ-016 While o_stall_a=1, i_a_we is ignored; upstream holds the A request and re-presents it once o_stall_a=0.
REQ-017 B with i_b_addr=0: o_b_ready=1 when granted, o_regWrite stays 0 in the next cycle.
REQ-018 4-bit starvation counter: +1 each cycle i_b_valid=1 and o_b_ready=0, saturating at STARVE_LIMIT; cleared on a B grant or when i_b_valid=0.
REQ-019 o_stall_a = (counter == STARVE_LIMIT), combinational from the counter register; the B grant follows in the same cycle.
REQ-020 Output stage carries a source flag (A/B) alongside the registered write.
REQ-021 Scoreboard set: i_issue=1 with i_issue_addr!=0 sets o_pending[i_issue_addr] at the next edge.
REQ-022 Scoreboard clear: the pending bit of o_wrAddr clears at the edge ending a cycle with o_regWrite=1 and source flag=B; an A write never clears a bit.
REQ-023 Set and clear of the same bit at the same edge: set wins.
REQ-024 o_pending[0] constant 0.
REQ-025 o_hazard = o_pending[i_Rs] | o_pending[i_Rt], combinational.
REQ-026 Issuing to an already-pending register leaves the bit set; at most one outstanding B write per register is guaranteed by o_hazard-based issue stalling upstream.

Reset
REQ-027 i_rst_n=0 immediately forces: o_regWrite=0, o_wrAddr=0, o_wrDataToReg=0, source flag=A, counter=0, o_pending=0, o_stall_a=0, o_hazard=0.
REQ-028 o_b_ready=0 during reset regardless of i_b_valid; normal operation resumes on the first rising edge after release.
REQ-029 Reset mid-operation discards any in-flight write and all pending bits, with no partial write.

Verification
REQ-030 A only: cycle 0 i_a_we=1, addr=5, data=0xDEADBEEF -> cycle 1 o_regWrite=1, o_wrAddr=5, o_wrDataToReg=0xDEADBEEF; cycle 2 o_regWrite=0.
REQ-031 Conflict, STARVE_LIMIT=4: A valid every cycle, B valid addr=9 data=0x11 from cycle 0 -> o_b_ready=0 in cycles 0-3; cycle 4 o_stall_a=1, o_b_ready=1; cycle 5 write addr=9 data=0x11, o_stall_a=0, counter=0.
REQ-032 Scoreboard: cycle 0 i_issue=1 addr=7 -> o_pending[7]=1 from cycle 1; i_Rt=7 gives o_hazard=1; B addr=7 granted in cycle 3 -> o_regWrite=1 in cycle 4; o_pending[7]=0 and o_hazard=0 in cycle 5.
REQ-033 Register zero: A addr=0 -> no write; issue addr=0 -> o_pending unchanged; B addr=0 -> o_b_ready=1, no write in the next cycle.
REQ-034 Same-edge set/clear: B write to reg 3 on the output stage while i_issue=1, addr=3 -> o_pending[3] remains 1.
REQ-035 Reset during a stall cycle (o_stall_a=1, o_pending=0x00000080) -> all outputs 0 asynchronously; after release an A request is granted normally.
